phase_accumulator: RTL and testbench
====================================

PHASE_ACCUMULATOR -- requirements
Module: phase_accumulator

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 24: accumulator width in bits.
REQ-002 SHALL have parameter PHASE_WIDTH, default 16: output phase width; phase = acc[ACC_WIDTH-1 -: PHASE_WIDTH].
REQ-003 SHALL have port clk  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port sample_tick  input  1  one-cycle strobe at audio sample rate.
REQ-006 SHALL have port tune_word  input  ACC_WIDTH  frequency increment per sample.
REQ-007 SHALL have port tune_valid  input  1  tune_word offered.
REQ-008 SHALL have port tune_ready  output  1  tune_word accepted when tune_valid && tune_ready.
REQ-009 SHALL have port note_on  input  1  one-cycle start/retrigger strobe.
REQ-010 SHALL have port note_off  input  1  one-cycle release strobe.
REQ-011 SHALL have port phase  output  PHASE_WIDTH  phase word for the sine lookup stage, in unsigned turns.
REQ-012 SHALL have port phase_valid  output  1  one-cycle strobe; phase is new this cycle.
REQ-013 SHALL have port active  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL implement the states IDLE, RUN and STOPPING.
REQ-015 SHALL, in IDLE on note_on, clear acc to 0 and enter RUN; a sample_tick in the same cycle SHALL produce no output.
REQ-016 SHALL, on a sample_tick in RUN or STOPPING, register phase <= acc top bits (pre-add value) and acc <= acc + inc, and assert phase_valid for exactly the following cycle (1-cycle latency).
REQ-017 SHALL, in RUN, let acc wrap modulo 2^ACC_WIDTH and discard the carry.
REQ-018 SHALL, in RUN on note_on, restart: a simultaneous tick outputs phase 0 and sets acc <= inc; without a tick, acc <= 0.
REQ-019 SHALL, in RUN on note_off, enter STOPPING.
REQ-020 SHALL, in STOPPING on a tick whose add produces a carry out, output the pre-add phase, set acc <= 0 and enter IDLE; no further phase_valid SHALL occur until the next note_on.
REQ-021 SHALL, in STOPPING on note_on, return to RUN without clearing acc.
REQ-022 SHALL give note_on priority when note_on and note_off are asserted together; note_off SHALL be ignored in IDLE.
REQ-023 SHALL, on acceptance of a tune_word, store it in a shadow register, set pending and drive tune_ready low.
REQ-024 SHALL, while pending, copy the shadow to inc: in IDLE on the next clock, otherwise at the next tick; that tick's add SHALL use the new inc, and pending SHALL then clear.
REQ-025 SHALL generate no phase_valid when sample_tick is low; phase SHALL hold its last value between ticks.

Reset
REQ-026 SHALL, while reset is asserted, force state=IDLE, acc=0, inc=0, shadow=0, pending=0, phase=0, phase_valid=0, active=0 and tune_ready=1, irrespective of clk.
REQ-027 SHALL, on reset asserted mid-note, abort immediately with no further phase_valid, and require a fresh note_on after reset releases.

Verification
REQ-028 Bench SHALL cover: tune 0x010000 in IDLE, note_on, 3 ticks -> phase 0x0000, 0x0100, 0x0200, each phase_valid one cycle after its tick.
REQ-029 Bench SHALL cover: inc 0x010000 with acc 0xFF0000 in RUN, tick -> phase 0xFF00, acc wraps to 0x000000, state stays RUN.
REQ-030 Bench SHALL cover: inc 0x400000, note_on, 3 ticks (0x0000, 0x4000, 0x8000), note_off, tick -> phase 0xC000, active=0 next cycle, later ticks produce no phase_valid.
REQ-031 Bench SHALL cover: in RUN, tune_valid with 0x020000 between ticks -> tune_ready low until the next tick, which adds 0x020000, then tune_ready=1.
REQ-032 Bench SHALL cover: note_on and note_off in the same cycle while in RUN -> acc restarts, state stays RUN.
REQ-033 Bench SHALL cover: reset pulsed mid-note asynchronously between clock edges -> all outputs at REQ-026 values immediately, then no phase_valid on ticks until note_on.

Source files
------------

// File: rtl/phase_accumulator.sv
// Phase accumulator for a wavetable oscillator: per-sample phase
// stepping with note start/retrigger/release and a shadowed tune word.
module phase_accumulator #(
  parameter int ACC_WIDTH   = 24,
  parameter int PHASE_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sample_tick,
  input  logic [ACC_WIDTH-1:0]   tune_word,
  input  logic                   tune_valid,
  output logic                   tune_ready,
  input  logic                   note_on,
  input  logic                   note_off,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic                   phase_valid,
  output logic                   active
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOPPING
  } state_t;

  state_t                 state, state_n;
  logic [ACC_WIDTH-1:0]   acc, acc_n;
  logic [ACC_WIDTH-1:0]   inc, inc_n;
  logic [ACC_WIDTH-1:0]   shadow, shadow_n;
  logic                   pending, pending_n;
  logic [PHASE_WIDTH-1:0] phase_n;
  logic                   phase_valid_n;
  logic [ACC_WIDTH-1:0]   inc_eff;
  logic [ACC_WIDTH:0]     sum;
  logic [PHASE_WIDTH-1:0] acc_top;

  assign tune_ready = !pending;
  assign active     = (state != IDLE);
  assign acc_top    = acc[ACC_WIDTH-1 -: PHASE_WIDTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      inc         <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      phase       <= '0;
      phase_valid <= 1'b0;
    end else begin
      state       <= state_n;
      acc         <= acc_n;
      inc         <= inc_n;
      shadow      <= shadow_n;
      pending     <= pending_n;
      phase       <= phase_n;
      phase_valid <= phase_valid_n;
    end
  end

  always_comb begin
    // a pending tune word takes effect on the very tick that loads it
    inc_eff       = pending ? shadow : inc;
    sum           = {1'b0, acc} + {1'b0, inc_eff};
    state_n       = state;
    acc_n         = acc;
    inc_n         = inc;
    shadow_n      = shadow;
    pending_n     = pending;
    phase_n       = phase;
    phase_valid_n = 1'b0;

    unique case (state)
      IDLE: begin
        if (note_on) begin
          acc_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        if (note_on) begin
          acc_n = '0;
          if (sample_tick) begin
            phase_n       = '0;
            phase_valid_n = 1'b1;
            acc_n         = inc_eff;
          end
        end else begin
          if (sample_tick) begin
            phase_n       = acc_top;
            phase_valid_n = 1'b1;
            acc_n         = sum[ACC_WIDTH-1:0];
          end
          if (note_off) state_n = STOPPING;
        end
      end
      STOPPING: begin
        if (sample_tick) begin
          phase_n       = acc_top;
          phase_valid_n = 1'b1;
          acc_n         = sum[ACC_WIDTH-1:0];
        end
        // release completes at the end of the current cycle of the wave
        if (note_on) begin
          state_n = RUN;
        end else if (sample_tick && sum[ACC_WIDTH]) begin
          acc_n   = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (pending && (state == IDLE || sample_tick)) begin
      inc_n     = shadow;
      pending_n = 1'b0;
    end else if (tune_valid && !pending) begin
      shadow_n  = tune_word;
      pending_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_phase_accumulator.sv
// Scoreboard bench for phase_accumulator: expected phases are queued
// with their due cycle when a tick is driven and popped on phase_valid.
module tb_phase_accumulator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic [23:0] tune_word = '0;
  logic        tune_valid = 1'b0;
  logic        tune_ready;
  logic        note_on = 1'b0;
  logic        note_off = 1'b0;
  logic [15:0] phase;
  logic        phase_valid;
  logic        active;

  typedef struct {
    int          due;
    logic [15:0] ph;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;

  phase_accumulator #(.ACC_WIDTH(24), .PHASE_WIDTH(16)) dut (
    .clk(clk),
    .reset(reset),
    .sample_tick(sample_tick),
    .tune_word(tune_word),
    .tune_valid(tune_valid),
    .tune_ready(tune_ready),
    .note_on(note_on),
    .note_off(note_off),
    .phase(phase),
    .phase_valid(phase_valid),
    .active(active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front();
        n_checks++;
        if (phase_valid !== 1'b1 || phase !== e.ph) begin
          n_fails++;
          $display("FAIL phase_out: valid=%b phase=%h, need valid=1 phase=%h",
                   phase_valid, phase, e.ph);
        end
      end else begin
        if (q.size() != 0 && q[0].due < cyc) begin
          e = q.pop_front();
          n_checks++;
          n_fails++;
          $display("FAIL missed_phase: no phase_valid, need phase=%h", e.ph);
        end
        if (phase_valid !== 1'b0) begin
          n_checks++;
          n_fails++;
          $display("FAIL spurious_valid: phase_valid=%b phase=%h, need valid=0",
                   phase_valid, phase);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit t, input bit on, input bit off,
                       input bit exp, input logic [15:0] ph);
    sample_tick = t;
    note_on     = on;
    note_off    = off;
    if (exp) q.push_back('{cyc + 1, ph});
    step();
    sample_tick = 1'b0;
    note_on     = 1'b0;
    note_off    = 1'b0;
    step();
  endtask

  task automatic tick(input logic [15:0] ph);
    pulse(1'b1, 1'b0, 1'b0, 1'b1, ph);
  endtask

  task automatic tune(input logic [23:0] w);
    tune_word  = w;
    tune_valid = 1'b1;
    step();
    tune_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (phase !== 16'h0 || phase_valid !== 1'b0 ||
        active !== 1'b0 || tune_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL reset_state: ph=%h pv=%b act=%b rdy=%b, need 0 0 0 1",
               phase, phase_valid, active, tune_ready);
    end
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    tune(24'h010000);
    n_checks++;
    if (tune_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL idle_tune_busy: rdy=%b, need 0", tune_ready);
    end
    step();
    n_checks++;
    if (tune_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL idle_tune_load: rdy=%b, need 1", tune_ready);
    end
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    n_checks++;
    if (active !== 1'b1) begin
      n_fails++;
      $display("FAIL note_on_active: act=%b, need 1", active);
    end
    tick(16'h0000);
    tick(16'h0100);
    tick(16'h0200);
    step();
    n_checks++;
    if (phase !== 16'h0200) begin
      n_fails++;
      $display("FAIL phase_hold: phase=%h, need 0200", phase);
    end
  endtask

  task automatic test_wrap();
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    tune(24'hFF0000);
    tick(16'h0000);
    n_checks++;
    if (tune_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL tune_release: rdy=%b, need 1", tune_ready);
    end
    tune(24'h010000);
    tick(16'hFF00);
    tick(16'h0000);
    n_checks++;
    if (active !== 1'b1) begin
      n_fails++;
      $display("FAIL wrap_stays_run: act=%b, need 1", active);
    end
    tick(16'h0100);
  endtask

  task automatic test_retune();
    tune(24'h020000);
    step();
    step();
    step();
    n_checks++;
    if (tune_ready !== 1'b0) begin
      n_fails++;
      $display("FAIL retune_busy: rdy=%b, need 0", tune_ready);
    end
    tick(16'h0200);
    n_checks++;
    if (tune_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL retune_ready: rdy=%b, need 1", tune_ready);
    end
    tick(16'h0400);
    tick(16'h0600);
  endtask

  task automatic test_on_off_same_cycle();
    pulse(1'b0, 1'b1, 1'b1, 1'b0, 16'h0);
    n_checks++;
    if (active !== 1'b1) begin
      n_fails++;
      $display("FAIL on_off_active: act=%b, need 1", active);
    end
    tick(16'h0000);
    pulse(1'b1, 1'b1, 1'b1, 1'b1, 16'h0000);
    tick(16'h0200);
  endtask

  task automatic test_stop();
    tune(24'h400000);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    tick(16'h0000);
    tick(16'h4000);
    tick(16'h8000);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    n_checks++;
    if (active !== 1'b1) begin
      n_fails++;
      $display("FAIL stopping_active: act=%b, need 1", active);
    end
    sample_tick = 1'b1;
    q.push_back('{cyc + 1, 16'hC000});
    step();
    sample_tick = 1'b0;
    n_checks++;
    if (active !== 1'b0) begin
      n_fails++;
      $display("FAIL stop_idle: act=%b, need 0", active);
    end
    step();
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    n_checks++;
    if (active !== 1'b0 || phase !== 16'hC000) begin
      n_fails++;
      $display("FAIL idle_off: act=%b phase=%h, need 0 C000", active, phase);
    end
  endtask

  task automatic test_resume();
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    tick(16'h0000);
    pulse(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    tick(16'h4000);
    tick(16'h8000);
    tick(16'hC000);
    tick(16'h0000);
    n_checks++;
    if (active !== 1'b1) begin
      n_fails++;
      $display("FAIL resume_run: act=%b, need 1", active);
    end
  endtask

  task automatic test_reset_mid();
    tick(16'h4000);
    tune(24'h123456);
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if (phase !== 16'h0 || phase_valid !== 1'b0 ||
        active !== 1'b0 || tune_ready !== 1'b1) begin
      n_fails++;
      $display("FAIL async_reset: ph=%h pv=%b act=%b rdy=%b, need 0 0 0 1",
               phase, phase_valid, active, tune_ready);
    end
    #3;
    step();
    reset = 1'b0;
    step();
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    n_checks++;
    if (active !== 1'b0) begin
      n_fails++;
      $display("FAIL post_reset_idle: act=%b, need 0", active);
    end
    pulse(1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    tick(16'h0000);
    tick(16'h0000);
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_wrap();
    test_retune();
    test_on_off_same_cycle();
    test_stop();
    test_resume();
    test_reset_mid();
    step();
    step();
    n_checks++;
    if (q.size() != 0) begin
      n_fails++;
      $display("FAIL drain: %0d expected phases left, need 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
